// File: rtl/ir_key_filter.sv
// ir_key_filter: validates decoded IR frames, suppresses key repeats, queues keys in a 4-deep FIFO
module ir_key_filter #(
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          HOLD_MS    = 150,
   parameter int          ADDR_CHECK = 1,
   parameter logic [15:0] ADDR_MATCH = 16'hFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] irdata,
   input  logic [15:0] iraddr,
   input  logic        get_flag,
   output logic [7:0]  key_data,
   output logic        key_valid,
   input  logic        key_rd,
   output logic        key_held,
   output logic [2:0]  key_count,
   output logic        frame_err,
   output logic        fifo_ovf
);
   localparam int DIV = CLK_HZ / 1000;
   localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(HOLD_MS + 1);
   typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
   state_t        state_q, state_d;
   logic [15:0]   data_q, addr_q;
   logic          ok_q;
   logic [PW-1:0] pre_q;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    last_cmd_q;
   logic          last_valid_q;
   logic          held_q, held_d;
   logic [7:0]    mem_q [4];
   logic [1:0]    wp_q, rp_q, rp_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    key_data_q, key_data_d;
   logic          tick, good, rep, push_req, push, pop, full;
   // Next-state, frame decision, timer and FIFO bookkeeping
   always_comb begin
      state_d    = state_q == IDLE ? (get_flag ? CHECK : IDLE) : state_q == CHECK ? COMMIT : IDLE;
      tick       = pre_q == PW'(DIV - 1);
      good       = state_q == COMMIT && ok_q;
      rep        = last_valid_q && data_q[7:0] == last_cmd_q && timer_q < TW'(HOLD_MS);
      push_req   = good && !rep;
      full       = cnt_q == 3'd4;
      pop        = key_rd && cnt_q != 3'd0;
      push       = push_req && (!full || pop);
      frame_err  = state_q == COMMIT && !ok_q;
      fifo_ovf   = push_req && full && !pop;
      timer_d    = good ? '0 : (tick && timer_q < TW'(HOLD_MS)) ? timer_q + 1'b1 : timer_q;
      held_d     = good ? rep : timer_d == TW'(HOLD_MS) ? 1'b0 : held_q;
      cnt_d      = cnt_q + {2'b0, push} - {2'b0, pop};
      rp_d       = rp_q + {1'b0, pop};
      key_data_d = cnt_d == 3'd0 ? key_data_q : (push && rp_d == wp_q) ? data_q[7:0] : mem_q[rp_d];
   end
   // State, frame latch, repeat tracking, prescaler and FIFO pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         data_q       <= '0;
         addr_q       <= '0;
         ok_q         <= 1'b0;
         pre_q        <= '0;
         timer_q      <= TW'(HOLD_MS);
         last_cmd_q   <= '0;
         last_valid_q <= 1'b0;
         held_q       <= 1'b0;
         wp_q         <= '0;
         rp_q         <= '0;
         cnt_q        <= '0;
         key_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         pre_q      <= tick ? '0 : pre_q + 1'b1;
         timer_q    <= timer_d;
         held_q     <= held_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         key_data_q <= key_data_d;
         if (state_q == IDLE && get_flag) begin
            data_q <= irdata;
            addr_q <= iraddr;
         end
         if (state_q == CHECK)
            ok_q <= data_q[15:8] == ~data_q[7:0] && (ADDR_CHECK == 0 || addr_q == ADDR_MATCH);
         if (push_req) begin
            last_cmd_q   <= data_q[7:0];
            last_valid_q <= 1'b1;
         end
         if (push)
            wp_q <= wp_q + 1'b1;
      end
   end
   // FIFO storage needs no reset; occupancy guards every read
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wp_q] <= data_q[7:0];
   end
   assign key_valid = cnt_q != 3'd0;
   assign key_count = cnt_q;
   assign key_data  = key_data_q;
   assign key_held  = held_q;
endmodule

// File: tb/tb_ir_key_filter.sv
// tb_ir_key_filter: directed checks of validation, repeat window, FIFO order/overflow and reset
module tb_ir_key_filter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] irdata = '0;
   logic [15:0] iraddr = '0;
   logic        get_flag = 1'b0;
   logic        key_rd = 1'b0;
   logic [7:0]  key_data;
   logic        key_valid;
   logic        key_held;
   logic [2:0]  key_count;
   logic        frame_err;
   logic        fifo_ovf;
   int          passed = 0;
   int          total = 0;

   ir_key_filter #(.CLK_HZ(10_000), .HOLD_MS(150), .ADDR_CHECK(1), .ADDR_MATCH(16'hFF00)) dut (
      .clk(clk), .rst(rst), .irdata(irdata), .iraddr(iraddr), .get_flag(get_flag),
      .key_data(key_data), .key_valid(key_valid), .key_rd(key_rd), .key_held(key_held),
      .key_count(key_count), .frame_err(frame_err), .fifo_ovf(fifo_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge inside CHECK
   task automatic send(input logic [15:0] d, input logic [15:0] a);
      @(negedge clk);
      irdata = d;
      iraddr = a;
      get_flag = 1'b1;
      @(negedge clk);
      get_flag = 1'b0;
   endtask

   task automatic pop;
      @(negedge clk);
      key_rd = 1'b1;
      @(negedge clk);
      key_rd = 1'b0;
   endtask

   task automatic send_key(input logic [7:0] k);
      send({~k, k}, 16'hFF00);
      wait_n(2);
   endtask

   initial begin
      #1;
      chk("rst_valid", 32'(key_valid), 0);
      chk("rst_data", 32'(key_data), 0);
      chk("rst_count", 32'(key_count), 0);
      chk("rst_held", 32'(key_held), 0);
      chk("rst_err", 32'(frame_err), 0);
      chk("rst_ovf", 32'(fifo_ovf), 0);
      wait_n(3);
      rst = 1'b0;
      wait_n(2);

      send(16'hBA45, 16'hFF00);
      chk("lat_check_valid", 32'(key_valid), 0);
      wait_n(1);
      chk("lat_commit_valid", 32'(key_valid), 0);
      chk("lat_commit_err", 32'(frame_err), 0);
      wait_n(1);
      chk("lat_valid", 32'(key_valid), 1);
      chk("lat_data", 32'(key_data), 32'h45);
      chk("lat_count", 32'(key_count), 1);
      pop();
      chk("pop_valid", 32'(key_valid), 0);
      chk("pop_hold_data", 32'(key_data), 32'h45);
      pop();
      chk("empty_rd_count", 32'(key_count), 0);

      send(16'hBB45, 16'hFF00);
      wait_n(1);
      chk("badcmp_err", 32'(frame_err), 1);
      wait_n(1);
      chk("badcmp_err_end", 32'(frame_err), 0);
      chk("badcmp_count", 32'(key_count), 0);
      send(16'hBA45, 16'hFE00);
      wait_n(1);
      chk("badaddr_err", 32'(frame_err), 1);
      wait_n(1);
      chk("badaddr_count", 32'(key_count), 0);

      wait_n(2000);
      send_key(8'h45);
      chk("rep1_count", 32'(key_count), 1);
      chk("rep1_held", 32'(key_held), 0);
      wait_n(1000);
      send_key(8'h45);
      chk("rep2_count", 32'(key_count), 1);
      chk("rep2_held", 32'(key_held), 1);
      wait_n(1000);
      send_key(8'h45);
      chk("rep3_count", 32'(key_count), 1);
      chk("rep3_held", 32'(key_held), 1);
      wait_n(1400);
      chk("hold_140ms", 32'(key_held), 1);
      wait_n(120);
      chk("hold_drop", 32'(key_held), 0);
      wait_n(470);
      send_key(8'h45);
      chk("rep4_count", 32'(key_count), 2);
      chk("rep4_held", 32'(key_held), 0);
      chk("rep4_head", 32'(key_data), 32'h45);
      pop();
      pop();
      chk("rep_drain", 32'(key_count), 0);

      for (int k = 1; k <= 4; k++) send_key(8'(k));
      chk("ovf_full", 32'(key_count), 4);
      send(16'hFA05, 16'hFF00);
      wait_n(1);
      chk("ovf_pulse", 32'(fifo_ovf), 1);
      wait_n(1);
      chk("ovf_end", 32'(fifo_ovf), 0);
      chk("ovf_count", 32'(key_count), 4);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf_order%0d", k), 32'(key_data), 32'(k));
         pop();
      end
      chk("ovf_drain", 32'(key_valid), 0);

      for (int k = 1; k <= 4; k++) send_key(8'(k));
      send(16'hF906, 16'hFF00);
      wait_n(1);
      key_rd = 1'b1;
      #1;
      chk("pp_no_ovf", 32'(fifo_ovf), 0);
      wait_n(1);
      key_rd = 1'b0;
      chk("pp_count", 32'(key_count), 4);
      chk("pp_head", 32'(key_data), 32'h02);
      pop();
      chk("pp_3", 32'(key_data), 32'h03);
      pop();
      chk("pp_4", 32'(key_data), 32'h04);
      pop();
      chk("pp_6", 32'(key_data), 32'h06);
      pop();
      chk("pp_empty", 32'(key_count), 0);

      send_key(8'h11);
      send_key(8'h12);
      chk("mid_pre_count", 32'(key_count), 2);
      send(16'hEC13, 16'hFF00);
      rst = 1'b1;
      #1;
      chk("mid_valid", 32'(key_valid), 0);
      chk("mid_count", 32'(key_count), 0);
      chk("mid_err", 32'(frame_err), 0);
      wait_n(1);
      rst = 1'b0;
      wait_n(1);
      chk("mid_after_err", 32'(frame_err), 0);
      chk("mid_after_count", 32'(key_count), 0);
      send_key(8'h14);
      chk("mid_next_count", 32'(key_count), 1);
      chk("mid_next_data", 32'(key_data), 32'h14);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
